// File: rtl/risc_pkg.sv
// Shared core types: data-memory access size plus the load/store unit's
// state type and byte-count helper.
package risc_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        TRPL = 2'd2,
        WORD = 2'd3
    } op_enum_dmem_size;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    function automatic logic [2:0] dmem_nbytes(input op_enum_dmem_size size);
        case (size)
            BYTE:    return 3'd1;
            HALF:    return 3'd2;
            TRPL:    return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align_chk.sv
// Flags an access whose bytes would cross a 32-bit word boundary.
module lsu_align_chk
    import risc_pkg::*;
(
    input  logic [1:0]       addr,
    input  op_enum_dmem_size size,
    output logic             misaligned
);

    assign misaligned = (({1'b0, addr}) + dmem_nbytes(size)) > 3'd4;

endmodule

// File: rtl/lsu_master.sv
// Single-outstanding load/store initiator between pipeline and data memory.
// Define LSU_ALIGN_CHECK_EN to reject word-crossing accesses with resp_err.
module lsu_master
    import risc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SYNC_READ  = 0
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  cpu_valid,
    output logic                  cpu_ready,
    input  logic                  cpu_we,
    input  op_enum_dmem_size      cpu_size,
    input  logic                  cpu_zero_ex,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    output logic                  mem_wen,
    output logic                  mem_ren,
    output logic                  mem_zero_ex,
    output op_enum_dmem_size      mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_e            state, next_state;
    logic                  req_we;
    op_enum_dmem_size      req_size;
    logic                  req_zero_ex;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  accept;
    logic                  capture;
    logic                  misaligned;

`ifdef LSU_ALIGN_CHECK_EN
    lsu_align_chk u_align_chk (
        .addr       (cpu_addr[1:0]),
        .size       (cpu_size),
        .misaligned (misaligned)
    );
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        next_state = state;
        cpu_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_req    = 1'b0;
        mem_wen    = 1'b0;
        mem_ren    = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_valid) begin
                    accept     = 1'b1;
                    next_state = misaligned ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_req = 1'b1;
                mem_wen = req_we;
                mem_ren = ~req_we;
                if (req_we) begin
                    next_state = RESP;
                end else if (SYNC_READ != 0) begin
                    next_state = WAIT;
                end else begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            WAIT: begin
                capture    = 1'b1;
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Response data is cleared on accept so stores and rejected requests return 0.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state       <= IDLE;
            req_we      <= 1'b0;
            req_size    <= BYTE;
            req_zero_ex <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                req_we      <= cpu_we;
                req_size    <= cpu_size;
                req_zero_ex <= cpu_zero_ex;
                req_addr    <= cpu_addr;
                req_wdata   <= cpu_wdata;
                rdata_q     <= '0;
                err_q       <= misaligned;
            end else if (capture) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_size    = req_size;
    assign mem_zero_ex = req_zero_ex;
    assign mem_addr    = req_addr;
    assign mem_wdata   = req_wdata;
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;

endmodule

// File: doc/lsu_master.md
# lsu_master

Load/store initiator that sits between the core pipeline and the byte-addressed data memory. Accepts one load or store per handshake from the pipeline, drives the memory's `req`/`wen`/`ren`/`mem_size`/`addr`/`wr_data`/`zero_ex` port for exactly one cycle, and captures the read data. Returns a registered response to the pipeline, with backpressure. Supports async-read and sync-read memory configurations.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data word width
- `SYNC_READ`, 0, must match the memory: 0 = read data valid in the same cycle as `req`, 1 = valid one cycle after `req`

Ports:
- `clk`  in  1  single clock for the whole block
- `res_n`  in  1  reset, synchronous, active-low
- `cpu_valid`  in  1  request valid
- `cpu_ready`  out  1  request accepted when `cpu_valid & cpu_ready`
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_size`  in  `op_enum_dmem_size`  BYTE/HALF/TRPL/WORD
- `cpu_zero_ex`  in  1  zero-extend load
- `cpu_addr`  in  ADDR_WIDTH  byte address
- `cpu_wdata`  in  DATA_WIDTH  store data, low bytes used
- `resp_valid`  out  1  response valid
- `resp_ready`  in  1  pipeline takes response
- `resp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores and errors
- `resp_err`  out  1  misaligned access (see Configuration)
- `mem_req`, `mem_wen`, `mem_ren`, `mem_zero_ex`  out  1 each  memory controls
- `mem_size`  out  `op_enum_dmem_size`  memory access size
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_rdata`  in  DATA_WIDTH  memory read data, already extended

## Operation
- FSM states are IDLE, ACCESS, WAIT and RESP.
  - IDLE: `cpu_ready=1`. On handshake, register `we`, `size`, `zero_ex`, `addr` and `wdata`, then go to ACCESS. Without a handshake, stay in IDLE.
  - ACCESS: `cpu_ready=0`, `mem_req=1`, `mem_wen=we`, `mem_ren=~we`, and the `mem_*` outputs come from the registered request for exactly this cycle.
    - Store: go to RESP with `resp_rdata=0`.
    - Load with `SYNC_READ=0`: capture `mem_rdata` at the end of ACCESS, then go to RESP.
    - Load with `SYNC_READ=1`: go to WAIT.
  - WAIT (`SYNC_READ=1`, loads only): `mem_req=0`, `mem_size`/`mem_zero_ex` still driven from the registered request, capture `mem_rdata`, go to RESP.
  - RESP: `resp_valid=1`; `resp_rdata`/`resp_err` are held stable until `resp_valid & resp_ready`, then go to IDLE.
- Outside ACCESS, `mem_req`, `mem_wen` and `mem_ren` are 0. `mem_addr` and `mem_wdata` hold their last registered values.
- Only one request is outstanding at a time. There is no pipelining.
- Reset (`res_n=0` at a clk edge, in any state, including mid-ACCESS) has these effects:
  - state goes to IDLE;
  - all registered request fields, `resp_rdata` and `resp_err` become 0;
  - `resp_valid=0`, `mem_req=0`, `mem_wen=0`, `mem_ren=0`;
  - `cpu_ready=1` from the first cycle after reset;
  - a store in flight may or may not have been written.

## Timing
- Handshake at edge 0 drives `mem_req=1` during cycle 1.
- `resp_valid` rises at edge 2 (`SYNC_READ=0` or store) or at edge 3 (`SYNC_READ=1` load).
- If `resp_ready` is held at 1, the next request can be accepted one cycle after the response handshake. Minimum spacing is 3 cycles (async) or 4 cycles (sync load).
- `cpu_ready` is combinational from state only. It never depends on `cpu_valid`.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - A request is misaligned when `addr[1:0] + nbytes(size) > 4`, i.e. it crosses a word boundary.
  - A misaligned request skips ACCESS/WAIT: there is no `mem_req`. It goes IDLE→RESP with `resp_err=1` and `resp_rdata=0`, with `resp_valid` at edge 1.
- `LSU_ALIGN_CHECK_EN` undefined:
  - All addresses go to memory unchanged, since the memory handles unaligned byte addressing.
  - `resp_err` is tied to 0.

## Structure
- `risc_pkg` additions:
  - `lsu_state_e` (IDLE, ACCESS, WAIT, RESP);
  - `function dmem_nbytes(op_enum_dmem_size)`, returning 1/2/3/4.
- `op_enum_dmem_size` is reused from `risc_pkg` unchanged.
- One sub-module, `lsu_align_chk`: combinational, inputs `addr[1:0]` and `size`, output `misaligned`. It is instantiated only under `LSU_ALIGN_CHECK_EN`.

## Test plan
- Store then load, `SYNC_READ=0`:
  - Store WORD `0xDEADBEEF` @ `0x8` → `mem_req`/`mem_wen` high for one cycle, then `resp_valid` at edge 2 with `resp_rdata=0`.
  - Load WORD @ `0x8` → `resp_rdata=0xDEADBEEF` at edge 2.
- Sign vs zero extension, `SYNC_READ=1`: after byte `0x80` is stored @ `0x3`:
  - Load BYTE with `zero_ex=0` → `0xFFFFFF80`, `resp_valid` at edge 3.
  - Same load with `zero_ex=1` → `0x00000080`.
- Backpressure: `resp_ready=0` for 5 cycles after `resp_valid`:
  - `resp_rdata` is stable, `cpu_ready=0`, `mem_req=0` throughout.
  - A `cpu_valid` issued meanwhile is not accepted until the cycle after the response handshake.
- Misalignment, with the macro defined:
  - HALF @ `0x3` → `resp_err=1`, `resp_rdata=0`, no `mem_req` pulse.
  - HALF @ `0x2` → `resp_err=0` and a normal access.
- Misalignment, with the macro undefined:
  - HALF @ `0x3` → access issued with `mem_addr=0x3`, `resp_err=0`.
- Reset mid-operation: `res_n=0` during ACCESS of a load → next cycle state is IDLE, `resp_valid=0`, `mem_req=0`, `cpu_ready=1`, and no spurious response afterwards.
